// File: rtl/check_node_ms.sv
// Min-sum LDPC check node: snapshots one row of variable messages, scans them
// serially for the two smallest magnitudes and sign parity, then returns extrinsic messages.
module check_node_ms #(
  parameter int weight       = 6,
  parameter int float_length = 15,
  parameter int offset       = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [weight*float_length-1:0]   variable_value_input,
  input  logic [weight-1:0]                variable_enable_input,
  input  logic                             decision_down,
  output logic [weight*float_length-1:0]   check_value_output,
  output logic                             check_enable_output
);

  localparam int MW = float_length - 1;
  localparam int IW = $clog2(weight);
  localparam logic [MW-1:0] MAX_MAG = '1;
  localparam logic [MW-1:0] OFF_MAG = MW'(offset);
  localparam logic [IW-1:0] LAST_IDX = IW'(weight - 1);
  localparam logic [float_length-1:0] MOST_NEG = {1'b1, {MW{1'b0}}};

  typedef enum logic [1:0] {COLLECT, SCAN, GEN, WAIT} state_t;

  state_t state, state_next;
  logic   capture, scan_step, gen_load, release_out;

  logic [float_length-1:0] snap [weight];
  logic [IW-1:0]           scan_idx, min1_idx;
  logic [MW-1:0]           min1, min2;
  logic                    parity;

  logic [float_length-1:0]        cur;
  logic                           cur_sign;
  logic [MW-1:0]                  cur_mag;
  logic [weight*float_length-1:0] gen_value;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  // NOTE: each combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (&variable_enable_input) state_next = SCAN;
      SCAN:    if (scan_idx == LAST_IDX)    state_next = GEN;
      GEN:                                  state_next = WAIT;
      WAIT:    if (decision_down)           state_next = COLLECT;
      default:                              state_next = COLLECT;
    endcase
  end

  always_comb begin
    capture     = (state == COLLECT) && (&variable_enable_input);
    scan_step   = (state == SCAN);
    gen_load    = (state == GEN);
    release_out = (state == WAIT) && decision_down;
  end

  // Single shared magnitude path; the most negative code saturates to the max magnitude.
  always_comb begin
    cur      = snap[scan_idx];
    cur_sign = cur[float_length-1];
    if (!cur_sign)          cur_mag = cur[MW-1:0];
    else if (cur == MOST_NEG) cur_mag = MAX_MAG;
    else                    cur_mag = ~cur[MW-1:0] + MW'(1);
  end

  for (genvar g = 0; g < weight; g++) begin : g_slot
    logic [MW-1:0]           m, m_off;
    logic [float_length-1:0] m_ext;
    logic                    s;
    assign m     = (IW'(g) == min1_idx) ? min2 : min1;
    assign m_off = (m > OFF_MAG) ? (m - OFF_MAG) : '0;
    assign m_ext = {1'b0, m_off};
    assign s     = parity ^ snap[g][float_length-1];
    assign gen_value[g*float_length +: float_length] = s ? -m_ext : m_ext;
  end

  // NOTE: the snapshot array is small flop storage, not a RAM, so it is cleared on reset too.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < weight; i++) snap[i] <= '0;
      scan_idx            <= '0;
      min1_idx            <= '0;
      min1                <= '0;
      min2                <= '0;
      parity              <= 1'b0;
      check_value_output  <= '0;
      check_enable_output <= 1'b0;
    end else begin
      if (capture) begin
        for (int i = 0; i < weight; i++)
          snap[i] <= variable_value_input[i*float_length +: float_length];
        scan_idx <= '0;
        min1_idx <= '0;
        min1     <= MAX_MAG;
        min2     <= MAX_MAG;
        parity   <= 1'b0;
      end
      if (scan_step) begin
        parity   <= parity ^ cur_sign;
        scan_idx <= scan_idx + IW'(1);
        // Strict compares keep the lower index as min1 on ties; the tie lands in min2.
        if (cur_mag < min1) begin
          min2     <= min1;
          min1     <= cur_mag;
          min1_idx <= scan_idx;
        end else if (cur_mag < min2) begin
          min2 <= cur_mag;
        end
      end
      if (gen_load) begin
        check_value_output  <= gen_value;
        check_enable_output <= 1'b1;
      end
      if (release_out) check_enable_output <= 1'b0;
    end
  end

endmodule

// File: tb/tb_check_node_ms.sv
// Randomized scoreboard bench for check_node_ms: two instances (offset 0 and 2)
// share stimulus; a monitor compares each released result against a reference model.
module tb_check_node_ms;

  localparam int W  = 3;
  localparam int FL = 15;
  localparam int VW = W * FL;

  logic          clk = 1'b0;
  logic          rst;
  logic [VW-1:0] vin;
  logic [W-1:0]  ven;
  logic          dd;
  logic [VW-1:0] v0, v1;
  logic          en0, en1;

  always #5 clk = ~clk;

  check_node_ms #(.weight(W), .float_length(FL), .offset(0)) dut0 (
    .clk(clk), .rst(rst), .variable_value_input(vin), .variable_enable_input(ven),
    .decision_down(dd), .check_value_output(v0), .check_enable_output(en0));

  check_node_ms #(.weight(W), .float_length(FL), .offset(2)) dut1 (
    .clk(clk), .rst(rst), .variable_value_input(vin), .variable_enable_input(ven),
    .decision_down(dd), .check_value_output(v1), .check_enable_output(en1));

  typedef struct {
    logic [VW-1:0] e0;
    logic [VW-1:0] e1;
    int            cap;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic          prev_en = 1'b0;
  logic [VW-1:0] hold0, hold1;
  logic [VW-1:0] last0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each slot gets the smallest magnitude among the other slots,
  // signed by the product of the other slots' signs.
  function automatic logic [VW-1:0] model(input int v[W], input int off);
    int mag[W];
    int k, other, negs, mm, o;
    logic [VW-1:0] res;
    logic [FL-1:0] t;
    res  = '0;
    negs = 0;
    for (int i = 0; i < W; i++) begin
      mag[i] = (v[i] < 0) ? -v[i] : v[i];
      if (mag[i] > 16383) mag[i] = 16383;
      if (v[i] < 0) negs++;
    end
    k = 0;
    for (int i = 1; i < W; i++) if (mag[i] < mag[k]) k = i;
    other = 16383;
    for (int i = 0; i < W; i++) if (i != k && mag[i] < other) other = mag[i];
    for (int i = 0; i < W; i++) begin
      mm = ((i == k) ? other : mag[k]) - off;
      if (mm < 0) mm = 0;
      o = (((negs - ((v[i] < 0) ? 1 : 0)) % 2) == 1) ? -mm : mm;
      t = FL'(o);
      res[i*FL +: FL] = t;
    end
    return res;
  endfunction

  function automatic logic [VW-1:0] pack(input int v[W]);
    logic [VW-1:0] p;
    for (int i = 0; i < W; i++) p[i*FL +: FL] = FL'(v[i]);
    return p;
  endfunction

  function automatic int rand_val();
    case ($urandom_range(0, 4))
      0:       return int'($urandom_range(0, 20)) - 10;
      1:       return -16384;
      2:       return ($urandom_range(0, 1) == 1) ? 16383 : 0;
      default: return int'($urandom_range(0, 32767)) - 16384;
    endcase
  endfunction

  function automatic logic [VW-1:0] rand_bus();
    int v[W];
    for (int i = 0; i < W; i++) v[i] = rand_val();
    return pack(v);
  endfunction

  // Monitor: pops an expectation on every rising check_enable_output.
  always @(posedge clk) begin
    #1;
    if (en0 && !prev_en) begin
      if (sb.size() == 0) begin
        check("spurious_enable", {63'd0, en0}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("latency", 64'(cyc), 64'(mon_e.cap + W + 1));
        check("out_off0", 64'(v0), 64'(mon_e.e0));
        check("out_off2", 64'(v1), 64'(mon_e.e1));
        check("enable_off2", {63'd0, en1}, 64'd1);
        hold0 = mon_e.e0;
        hold1 = mon_e.e1;
      end
    end else if (en0 && prev_en) begin
      check("hold_off0", 64'(v0), 64'(hold0));
      check("hold_off2", 64'(v1), 64'(hold1));
    end
    prev_en = en0;
  end

  task automatic capture(input int v[W]);
    @(negedge clk);
    vin = pack(v);
    ven = '1;
    last0 = model(v, 0);
    sb.push_back('{model(v, 0), model(v, 2), cyc + 1});
  endtask

  // Scrambles inputs and pulses decision_down while the node is busy, then releases it.
  task automatic finish_run();
    bit got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (en0) begin
        got = 1'b1;
        break;
      end
      vin = rand_bus();
      ven = W'($urandom);
      dd  = 1'($urandom);
    end
    if (!got) check("timeout_enable", {63'd0, en0}, 64'd1);
    dd  = 1'b0;
    ven = W'($urandom);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    dd  = 1'b1;
    ven = W'($urandom);
    @(posedge clk);
    #1;
    check("release_enable", {63'd0, en0}, 64'd0);
    check("release_keep", 64'(v0), 64'(last0));
    @(negedge clk);
    dd  = 1'b0;
    ven = '0;
  endtask

  task automatic run(input int a, input int b, input int c);
    int v[W];
    v[0] = a;
    v[1] = b;
    v[2] = c;
    capture(v);
    finish_run();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[W];
    rst = 1'b1;
    vin = '0;
    ven = '0;
    dd  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_en_off0", {63'd0, en0}, 64'd0);
    check("reset_val_off0", 64'(v0), 64'd0);
    check("reset_en_off2", {63'd0, en1}, 64'd0);
    check("reset_val_off2", 64'(v1), 64'd0);
    rst = 1'b0;

    run(5, -3, 7);
    run(4, -4, 9);
    run(-16384, -16384, 1);
    run(1, -1, 5);
    run(5, -3, 7);

    // Partial enables never capture.
    @(negedge clk);
    vin = rand_bus();
    ven = 3'b011;
    repeat (5) @(negedge clk);
    check("partial_no_capture", {63'd0, en0}, 64'd0);
    ven = '0;

    // Reset sampled at edge T+2 aborts the scan.
    v[0] = 9; v[1] = -2; v[2] = 6;
    capture(v);
    @(negedge clk);
    vin = rand_bus();
    ven = '0;
    @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    check("abort_en", {63'd0, en0}, 64'd0);
    check("abort_val", 64'(v0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run(-7, 12, -3);

    for (int r = 0; r < 40; r++) run(rand_val(), rand_val(), rand_val());

    repeat (3) @(negedge clk);
    if (sb.size() != 0) check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
